// File: rtl/elm_pkg.sv
// ---------------------------------------------------------------------------
// elm_pkg -- shared definitions for the Elm configuration sequencer.
//
// Contents:
//   - datapath / config-word widths
//   - config word layout (conf_t) and select bundle layout (sel_t)
//   - sequencer state enum
//   - allowed range of the write latency
// ---------------------------------------------------------------------------
package elm_pkg;

  localparam int DATA_WIDTH  = 16;   // Elm datapath width
  localparam int CONF_WIDTH  = 32;   // config word width (layout is fixed)
  localparam int SEL_WIDTH   = 16;   // select bundle width
  localparam int REP_WIDTH   = 8;    // repeat-count field width
  localparam int CONF_USED_W = 27;   // bits [26:0] carry meaning, [31:27] reserved

  // Config word field offsets
  localparam int SEL_LSB   = 0;
  localparam int REP_LSB   = 16;
  localparam int INC_R_BIT = 24;
  localparam int INC_W_BIT = 25;
  localparam int LAST_BIT  = 26;

  // Select bundle field offsets
  localparam int M_MUX1_LSB = 0;
  localparam int M_MUX2_LSB = 2;
  localparam int A_MUX1_BIT = 4;
  localparam int A_MUX2_LSB = 5;
  localparam int A1_BIT     = 7;
  localparam int A2_BIT     = 8;
  localparam int V_LINE_LSB = 9;
  localparam int H_LINE_LSB = 11;
  localparam int RAM_I_LSB  = 13;
  localparam int WE_BIT     = 15;

  // Write latency bounds
  localparam int WRLAT_MIN = 1;
  localparam int WRLAT_MAX = 7;

  // Select bundle, MSB first (matches the offsets above)
  typedef struct packed {
    logic       we;
    logic [1:0] ram_i;
    logic [1:0] h_line;
    logic [1:0] v_line;
    logic       a2;
    logic       a1;
    logic [1:0] a_mux2;
    logic       a_mux1;
    logic [1:0] m_mux2;
    logic [1:0] m_mux1;
  } sel_t;

  // Meaningful part of a config word, MSB first (bits [26:0])
  typedef struct packed {
    logic                 last;
    logic                 inc_w;
    logic                 inc_r;
    logic [REP_WIDTH-1:0] rep;
    sel_t                 sel;
  } conf_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/elm_seq_dly.sv
// ---------------------------------------------------------------------------
// elm_seq_dly -- DEPTH-stage shift register with synchronous clear.
// Carries the write controls so each write lines up with the Elm pipeline.
//
// Ports:
//   clk   in   clock
//   i_clr in   synchronous clear of every stage
//   i_d   in   W  data entering stage 0
//   o_q   out  W  data leaving the last stage (DEPTH cycles after i_d)
// ---------------------------------------------------------------------------
module elm_seq_dly #(
  parameter int W     = 9,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_sr [DEPTH];

  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_sr[i] <= '0;
      end
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/elm_seq.sv
// ---------------------------------------------------------------------------
// elm_seq -- configuration-driven sequencer for one Elm processing element.
//
// A local config memory holds micro-words. After start, each word is fetched
// (one bubble cycle), then executed rep+1 times, driving the Elm selects and
// data-memory addresses. Write enable / write address go through a WrLat-deep
// delay line so each write lands on the data computed for its step.
//
// Optional feature: define ELM_SEQ_PERF_EN to get a saturating busy-cycle
// counter on perf_cnt; otherwise perf_cnt is tied to 0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, pc_base      begin program at pc_base (sampled only in IDLE)
//   r_base, w_base      initial read / write addresses
//   abort               stop issuing, then drain pending writes
//   cfg_we/waddr/wdata  config memory write port (accepted only in IDLE)
//   busy, done          busy FETCH..DRAIN; done pulses on return to IDLE
//   cfg_err             sticky: config write attempted while busy
//   sel_o               Elm select bundle (sel_t layout)
//   r_addr              Elm read address
//   w_addr, we_ram      Elm write address / enable, delayed by WrLat
//   perf_cnt            busy-cycle counter
//   dbg_state           current sequencer state (state_t encoding)
//
// Control inputs are single-cycle level samples, not handshakes: start is
// acted on only when the sequencer is IDLE and is silently ignored otherwise;
// cfg_we is accepted only in IDLE, and a cfg_we while busy is dropped and
// flagged on cfg_err.
// ---------------------------------------------------------------------------
module elm_seq
  import elm_pkg::*;
#(
  parameter int AddrDMEM  = 8,
  parameter int AddrCMEM  = 6,
  parameter int ConfWidth = 32,
  parameter int WrLat     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AddrCMEM-1:0]  pc_base,
  input  logic [AddrDMEM-1:0]  r_base,
  input  logic [AddrDMEM-1:0]  w_base,
  input  logic                 abort,
  input  logic                 cfg_we,
  input  logic [AddrCMEM-1:0]  cfg_waddr,
  input  logic [ConfWidth-1:0] cfg_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  output logic [15:0]          sel_o,
  output logic [AddrDMEM-1:0]  r_addr,
  output logic [AddrDMEM-1:0]  w_addr,
  output logic                 we_ram,
  output logic [15:0]          perf_cnt,
  output logic [1:0]           dbg_state
);

  if (WrLat < WRLAT_MIN || WrLat > WRLAT_MAX) begin : g_bad_wrlat
    $error("elm_seq: WrLat out of range 1..7");
  end
  if (ConfWidth != CONF_WIDTH) begin : g_bad_conf
    $error("elm_seq: ConfWidth must be 32");
  end

  localparam logic [2:0] DRAIN_LAST = 3'(WrLat - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [AddrCMEM-1:0] r_pc;
  logic [AddrDMEM-1:0] r_raddr;
  logic [AddrDMEM-1:0] r_wcnt;
  logic [REP_WIDTH-1:0] r_cnt;
  logic [2:0]          r_drain_cnt;
  logic                r_done;
  logic                r_cfg_err;
  conf_t               r_word;
  logic [CONF_USED_W-1:0] r_cmem [2**AddrCMEM];

  sel_t                w_sel;
  logic                w_issue_we;
  logic                w_last_step;
  logic                w_prog_end;
  logic                w_drain_exit;
  logic                w_cfg_ok;
  logic                w_unused_rsvd;
  logic [AddrDMEM:0]   w_dly_in;
  logic [AddrDMEM:0]   w_dly_out;

  // Reserved config bits are never stored.
  assign w_unused_rsvd = ^cfg_wdata[ConfWidth-1:CONF_USED_W];

  assign w_cfg_ok    = cfg_we && (r_state == ST_IDLE);
  assign w_last_step = (r_cnt == r_word.rep);
  // Running off the end of config memory ends the program like a last word.
  assign w_prog_end  = r_word.last || (r_pc == '1);

  // ---------------------------------------------------------------------
  // Next-state and per-cycle issue
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_sel        = '0;
    w_issue_we   = 1'b0;
    w_drain_exit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        w_state_nxt = abort ? ST_DRAIN : ST_RUN;
      end
      ST_RUN: begin
        w_sel      = r_word.sel;
        w_issue_we = r_word.sel.we;
        if (abort) begin
          w_state_nxt = ST_DRAIN;
        end else if (w_last_step) begin
          w_state_nxt = w_prog_end ? ST_DRAIN : ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == DRAIN_LAST) begin
          w_state_nxt  = ST_IDLE;
          w_drain_exit = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // State, program counter, address counters, status
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_raddr     <= '0;
      r_wcnt      <= '0;
      r_cnt       <= '0;
      r_drain_cnt <= '0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_drain_exit;

      if (cfg_we && (r_state != ST_IDLE)) r_cfg_err <= 1'b1;

      if (r_state == ST_DRAIN) r_drain_cnt <= r_drain_cnt + 3'd1;
      else                     r_drain_cnt <= '0;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_pc      <= pc_base;
            r_raddr   <= r_base;
            r_wcnt    <= w_base;
            r_cfg_err <= 1'b0;
          end
        end
        ST_FETCH: begin
          r_cnt <= '0;
        end
        ST_RUN: begin
          // The step issued this cycle uses the current addresses; advance after.
          if (r_word.inc_r) r_raddr <= r_raddr + 1'b1;
          if (r_word.inc_w) r_wcnt  <= r_wcnt + 1'b1;
          r_cnt <= r_cnt + 1'b1;
          if (!abort && w_last_step && !w_prog_end) r_pc <= r_pc + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Config memory: single write port, synchronous read in FETCH.
  // Contents are deliberately not reset.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_cfg_ok) r_cmem[cfg_waddr] <= cfg_wdata[CONF_USED_W-1:0];
    if (r_state == ST_FETCH) r_word <= conf_t'(r_cmem[r_pc]);
  end

  // ---------------------------------------------------------------------
  // Write delay line: {issue we, write counter}. Reset flushes pending writes.
  // ---------------------------------------------------------------------
  assign w_dly_in = {w_issue_we, r_wcnt};

  elm_seq_dly #(
    .W     (AddrDMEM + 1),
    .DEPTH (WrLat)
  ) u_dly (
    .clk   (clk),
    .i_clr (rst),
    .i_d   (w_dly_in),
    .o_q   (w_dly_out)
  );

  // ---------------------------------------------------------------------
  // Optional busy-cycle counter
  // ---------------------------------------------------------------------
`ifdef ELM_SEQ_PERF_EN
  logic [15:0] r_perf;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_perf <= '0;
    end else if ((r_state != ST_IDLE) && (r_perf != 16'hFFFF)) begin
      r_perf <= r_perf + 16'd1;
    end
  end
  assign perf_cnt = r_perf;
`else
  assign perf_cnt = 16'd0;
`endif

  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign cfg_err   = r_cfg_err;
  assign sel_o     = w_sel;
  assign r_addr    = r_raddr;
  assign we_ram    = w_dly_out[AddrDMEM];
  assign w_addr    = w_dly_out[AddrDMEM-1:0];
  assign dbg_state = r_state;

endmodule

// File: tb/tb_elm_seq.sv
// ---------------------------------------------------------------------------
// tb_elm_seq -- directed self-checking bench for elm_seq (WrLat = 2).
// Inputs are driven 1 ns after a rising edge and outputs are sampled at the
// same point, so every check sees settled post-edge values.
// ---------------------------------------------------------------------------
module tb_elm_seq;
  import elm_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  pc_base;
  logic [7:0]  r_base;
  logic [7:0]  w_base;
  logic        abort;
  logic        cfg_we;
  logic [5:0]  cfg_waddr;
  logic [31:0] cfg_wdata;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic [15:0] sel_o;
  logic [7:0]  r_addr;
  logic [7:0]  w_addr;
  logic        we_ram;
  logic [15:0] perf_cnt;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  elm_seq #(
    .AddrDMEM (8),
    .AddrCMEM (6),
    .ConfWidth(32),
    .WrLat    (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pc_base  (pc_base),
    .r_base   (r_base),
    .w_base   (w_base),
    .abort    (abort),
    .cfg_we   (cfg_we),
    .cfg_waddr(cfg_waddr),
    .cfg_wdata(cfg_wdata),
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err),
    .sel_o    (sel_o),
    .r_addr   (r_addr),
    .w_addr   (w_addr),
    .we_ram   (we_ram),
    .perf_cnt (perf_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cfg_write(input logic [5:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_waddr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  // Returns one cycle after the start edge (the FETCH cycle, t+1).
  task automatic start_prog(input logic [5:0] pc, input logic [7:0] rb, input logic [7:0] wb);
    pc_base = pc; r_base = rb; w_base = wb; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 40 && !done; k++) tick();
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL %s done timeout: done=%b required 1", name, done);
    end
  endtask

  function automatic logic [15:0] exp_perf(input int n);
`ifdef ELM_SEQ_PERF_EN
    return 16'(n);
`else
    return 16'd0 + 16'(n * 0);
`endif
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    total++;
    if ({busy, done, cfg_err, sel_o, r_addr, w_addr, we_ram, perf_cnt, dbg_state} !== '0) begin
      bad++;
      $display("FAIL reset_init: outputs=%h required 0",
               {busy, done, cfg_err, sel_o, r_addr, w_addr, we_ram, perf_cnt, dbg_state});
    end
    // Reset in the middle of a program with a write pending in the delay line.
    cfg_write(6'd5, 32'h0703_8005);
    start_prog(6'd5, 8'h10, 8'h20);
    tick(); tick(); tick();   // t+4: first write visible
    total++;
    if (we_ram !== 1'b1 || w_addr !== 8'h20) begin
      bad++;
      $display("FAIL reset_pre: we_ram=%b w_addr=%h required 1 20", we_ram, w_addr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({busy, done, cfg_err, sel_o, r_addr, w_addr, we_ram, perf_cnt, dbg_state} !== '0) begin
      bad++;
      $display("FAIL reset_mid: outputs=%h required 0",
               {busy, done, cfg_err, sel_o, r_addr, w_addr, we_ram, perf_cnt, dbg_state});
    end
    tick();
    total++;
    if (we_ram !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_flush: we_ram=%b busy=%b required 0 0", we_ram, busy);
    end
  endtask

  task automatic test_idle_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL idle_abort: busy=%b done=%b state=%0d required 0 0 0", busy, done, dbg_state);
    end
  endtask

  // Word at the top of config memory: ends the program without the last bit.
  task automatic test_single();
    cfg_write(6'd63, 32'h0300_8005);
    start_prog(6'd63, 8'h10, 8'h20);
    total++;
    if (dbg_state !== ST_FETCH || sel_o !== 16'h0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_fetch: state=%0d sel=%h busy=%b required 1 0000 1", dbg_state, sel_o, busy);
    end
    tick();
    total++;
    if (sel_o !== 16'h8005 || r_addr !== 8'h10) begin
      bad++;
      $display("FAIL single_run: sel=%h r_addr=%h required 8005 10", sel_o, r_addr);
    end
    tick();
    total++;
    if (sel_o !== 16'h0 || we_ram !== 1'b0 || dbg_state !== ST_DRAIN) begin
      bad++;
      $display("FAIL single_t3: sel=%h we=%b state=%0d required 0000 0 3", sel_o, we_ram, dbg_state);
    end
    tick();
    total++;
    if (we_ram !== 1'b1 || w_addr !== 8'h20 || done !== 1'b0) begin
      bad++;
      $display("FAIL single_write: we=%b w_addr=%h done=%b required 1 20 0", we_ram, w_addr, done);
    end
    tick();
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || we_ram !== 1'b0 || perf_cnt !== exp_perf(4)) begin
      bad++;
      $display("FAIL single_done: done=%b busy=%b we=%b perf=%0d required 1 0 0 %0d",
               done, busy, we_ram, perf_cnt, exp_perf(4));
    end
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL single_pulse: done=%b required 0", done);
    end
  endtask

  task automatic test_repeat();
    logic [15:0] es;
    logic        ewe;
    logic [7:0]  ewa;
    logic [7:0]  era;
    cfg_write(6'd63, 32'h0303_8005);
    start_prog(6'd63, 8'h10, 8'h20);
    for (int i = 2; i <= 8; i++) begin
      tick();
      es  = (i >= 2 && i <= 5) ? 16'h8005 : 16'h0;
      ewe = (i >= 4 && i <= 7);
      ewa = 8'h20 + 8'(i - 4);
      era = 8'h10 + 8'(i - 2);
      total++;
      if (sel_o !== es || we_ram !== ewe || (ewe && w_addr !== ewa) ||
          (i <= 5 && r_addr !== era) || done !== (i == 8)) begin
        bad++;
        $display("FAIL repeat_t%0d: sel=%h we=%b wa=%h ra=%h done=%b required %h %b %h %h %b",
                 i, sel_o, we_ram, w_addr, r_addr, done, es, ewe, ewa, era, (i == 8));
      end
    end
  endtask

  task automatic test_two_words();
    logic [15:0] sel_tab [1:8];
    logic        busy_tab [1:8];
    logic [7:0]  ra_tab [1:8];
    sel_tab  = '{16'h0, 16'h0123, 16'h0123, 16'h0, 16'h8ABC, 16'h0, 16'h0, 16'h0};
    busy_tab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ra_tab   = '{8'h40, 8'h40, 8'h41, 8'h42, 8'h42, 8'h42, 8'h42, 8'h42};
    cfg_write(6'd0, 32'h0101_0123);   // rep=1, inc_r, we=0
    cfg_write(6'd1, 32'h0600_8ABC);   // rep=0, inc_w, last, we=1
    start_prog(6'd0, 8'h40, 8'h50);
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) tick();
      total++;
      if (sel_o !== sel_tab[i] || busy !== busy_tab[i] || r_addr !== ra_tab[i] ||
          we_ram !== (i == 7) || done !== (i == 8) || ((i == 7) && w_addr !== 8'h50)) begin
        bad++;
        $display("FAIL two_t%0d: sel=%h busy=%b ra=%h we=%b wa=%h done=%b required %h %b %h %b 50 %b",
                 i, sel_o, busy, r_addr, we_ram, w_addr, done,
                 sel_tab[i], busy_tab[i], ra_tab[i], (i == 7), (i == 8));
      end
    end
    total++;
    if (perf_cnt !== exp_perf(7)) begin
      bad++;
      $display("FAIL two_perf: perf=%0d required %0d", perf_cnt, exp_perf(7));
    end
  endtask

  task automatic test_wrap();
    logic [7:0] ea;
    ea = 8'hFE;
    cfg_write(6'd2, 32'h0503_0001);
    start_prog(6'd2, 8'hFE, 8'h00);
    for (int i = 2; i <= 5; i++) begin
      tick();
      total++;
      if (r_addr !== ea || sel_o !== 16'h0001) begin
        bad++;
        $display("FAIL wrap_t%0d: r_addr=%h sel=%h required %h 0001", i, r_addr, sel_o, ea);
      end
      ea = ea + 8'd1;
    end
    wait_done("wrap");
    tick();
  endtask

  task automatic test_abort();
    cfg_write(6'd3, 32'h0707_8005);
    start_prog(6'd3, 8'h00, 8'h30);
    tick();           // t+2 step 1
    tick();           // t+3 step 2
    total++;
    if (r_addr !== 8'h01 || sel_o !== 16'h8005) begin
      bad++;
      $display("FAIL abort_step2: r_addr=%h sel=%h required 01 8005", r_addr, sel_o);
    end
    abort = 1'b1;
    tick();           // t+4
    abort = 1'b0;
    total++;
    if (dbg_state !== ST_DRAIN || sel_o !== 16'h0 || we_ram !== 1'b1 || w_addr !== 8'h30) begin
      bad++;
      $display("FAIL abort_t4: state=%0d sel=%h we=%b wa=%h required 3 0000 1 30",
               dbg_state, sel_o, we_ram, w_addr);
    end
    tick();           // t+5
    total++;
    if (we_ram !== 1'b1 || w_addr !== 8'h31 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort_t5: we=%b wa=%h done=%b required 1 31 0", we_ram, w_addr, done);
    end
    tick();           // t+6
    total++;
    if (done !== 1'b1 || we_ram !== 1'b0 || busy !== 1'b0 || perf_cnt !== exp_perf(5)) begin
      bad++;
      $display("FAIL abort_done: done=%b we=%b busy=%b perf=%0d required 1 0 0 %0d",
               done, we_ram, busy, perf_cnt, exp_perf(5));
    end
  endtask

  task automatic test_cfg_err();
    cfg_write(6'd4, 32'h0400_0011);
    start_prog(6'd4, 8'h00, 8'h00);
    cfg_we = 1'b1; cfg_waddr = 6'd4; cfg_wdata = 32'h0400_0022;
    tick();           // t+2
    cfg_we = 1'b0;
    total++;
    if (cfg_err !== 1'b1 || sel_o !== 16'h0011) begin
      bad++;
      $display("FAIL cfgerr_set: cfg_err=%b sel=%h required 1 0011", cfg_err, sel_o);
    end
    pc_base = 6'd63; start = 1'b1;
    tick();           // t+3
    start = 1'b0;
    total++;
    if (dbg_state !== ST_DRAIN) begin
      bad++;
      $display("FAIL busy_start: state=%0d required 3", dbg_state);
    end
    wait_done("cfgerr");
    tick();
    total++;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL cfgerr_sticky: cfg_err=%b busy=%b required 1 0", cfg_err, busy);
    end
    start_prog(6'd4, 8'h00, 8'h00);
    total++;
    if (cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL cfgerr_clear: cfg_err=%b required 0", cfg_err);
    end
    tick();
    total++;
    if (sel_o !== 16'h0011) begin
      bad++;
      $display("FAIL cfg_unchanged: sel=%h required 0011", sel_o);
    end
    wait_done("cfgerr2");
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; pc_base = '0; r_base = '0; w_base = '0;
    abort = 1'b0; cfg_we = 1'b0; cfg_waddr = '0; cfg_wdata = '0;
    tick(); tick();
    rst = 1'b0;
    test_reset();
    test_idle_abort();
    test_single();
    test_repeat();
    test_two_words();
    test_wrap();
    test_abort();
    test_cfg_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
